// File: rtl/id_ex_control_stage.sv
// MIPS main-control decoder and ID/EX pipeline register with stall, flush and load-use bubbling.
// Optional sticky unsupported-opcode trap enabled by defining ILLEGAL_OP_TRAP_EN.
module id_ex_control_stage #(
  parameter int DATA_W        = 32,
  parameter bit ZERO_RS_GUARD = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [31:0]       id_instr,
  input  logic              id_valid,
  input  logic              flush,
  input  logic              ex_stall,
  output logic              hazard_stall,
  output logic              ex_valid,
  output logic [1:0]        ex_alu_op,
  output logic [5:0]        ex_funct,
  output logic              ex_reg_dst,
  output logic              ex_alu_src,
  output logic              ex_mem_read,
  output logic              ex_mem_write,
  output logic              ex_mem_to_reg,
  output logic              ex_reg_write,
  output logic              ex_branch,
  output logic              ex_jump,
  output logic [4:0]        ex_rs,
  output logic [4:0]        ex_rt,
  output logic [4:0]        ex_rd,
  output logic [DATA_W-1:0] ex_imm,
  output logic              illegal_op
);

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_J    = 6'b000010;

  // ctrl bit order, MSB first: reg_dst, alu_src, mem_read, mem_write, mem_to_reg, reg_write, branch, jump
  typedef struct packed {
    logic              valid;
    logic [1:0]        alu_op;
    logic [5:0]        funct;
    logic [7:0]        ctrl;
    logic [4:0]        rs;
    logic [4:0]        rt;
    logic [4:0]        rd;
    logic [DATA_W-1:0] imm;
  } ex_t;

  logic [5:0] w_op;
  logic       w_legal;
  logic       w_rt_use;
  logic [1:0] w_alu_op;
  logic [7:0] w_ctrl;
  logic       w_rt_hit;
  logic       w_zero_ok;
  logic       w_load;
  ex_t        w_dec;
  ex_t        r_ex;

  assign w_op = id_instr[31:26];

  always_comb begin
    w_legal  = 1'b1;
    w_rt_use = 1'b0;
    w_alu_op = 2'b00;
    w_ctrl   = 8'b0000_0000;
    case (w_op)
      OP_R:    begin w_alu_op = 2'b10; w_ctrl = 8'b1000_0100; w_rt_use = 1'b1; end
      OP_LW:   begin w_alu_op = 2'b00; w_ctrl = 8'b0110_1100; end
      OP_SW:   begin w_alu_op = 2'b00; w_ctrl = 8'b0101_0000; w_rt_use = 1'b1; end
      OP_BEQ:  begin w_alu_op = 2'b01; w_ctrl = 8'b0000_0010; w_rt_use = 1'b1; end
      OP_ADDI: begin w_alu_op = 2'b00; w_ctrl = 8'b0100_0100; end
      OP_J:    begin w_alu_op = 2'b00; w_ctrl = 8'b0000_0001; end
      default: w_legal = 1'b0;
    endcase
  end

  always_comb begin
    w_dec        = '0;
    w_dec.valid  = 1'b1;
    w_dec.alu_op = w_alu_op;
    w_dec.funct  = id_instr[5:0];
    w_dec.ctrl   = w_ctrl;
    w_dec.rs     = id_instr[25:21];
    w_dec.rt     = id_instr[20:16];
    w_dec.rd     = id_instr[15:11];
    w_dec.imm    = {{(DATA_W-16){id_instr[15]}}, id_instr[15:0]};
  end

  // Load-use: the load in EX writes ex_rt, which the ID instruction reads as rs or (if used) rt
  assign w_rt_hit  = (r_ex.rt == id_instr[25:21]) | (w_rt_use & (r_ex.rt == id_instr[20:16]));
  assign w_zero_ok = ZERO_RS_GUARD ? (r_ex.rt != 5'd0) : 1'b1;
  assign hazard_stall = r_ex.valid & r_ex.ctrl[5] & id_valid & w_rt_hit & w_zero_ok;
  assign w_load = id_valid & w_legal;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ex <= '0;
    end else if (flush) begin
      r_ex <= '0;
    end else if (ex_stall) begin
      r_ex <= r_ex;
    end else if (hazard_stall || !w_load) begin
      r_ex <= '0;
    end else begin
      r_ex <= w_dec;
    end
  end

`ifdef ILLEGAL_OP_TRAP_EN
  logic r_illegal;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_illegal <= 1'b0;
    end else if (!flush && !ex_stall && !hazard_stall && id_valid && !w_legal) begin
      r_illegal <= 1'b1;
    end
  end
  assign illegal_op = r_illegal;
`else
  assign illegal_op = 1'b0;
`endif

  assign ex_valid      = r_ex.valid;
  assign ex_alu_op     = r_ex.alu_op;
  assign ex_funct      = r_ex.funct;
  assign ex_reg_dst    = r_ex.ctrl[7];
  assign ex_alu_src    = r_ex.ctrl[6];
  assign ex_mem_read   = r_ex.ctrl[5];
  assign ex_mem_write  = r_ex.ctrl[4];
  assign ex_mem_to_reg = r_ex.ctrl[3];
  assign ex_reg_write  = r_ex.ctrl[2];
  assign ex_branch     = r_ex.ctrl[1];
  assign ex_jump       = r_ex.ctrl[0];
  assign ex_rs         = r_ex.rs;
  assign ex_rt         = r_ex.rt;
  assign ex_rd         = r_ex.rd;
  assign ex_imm        = r_ex.imm;

endmodule
